// File: rtl/uart_vector_rx.sv
// 8N1 serial receiver that assembles big-endian byte pairs into 16-bit words and
// publishes every N_NUMS words as one parallel vector with a single-cycle strobe.
module uart_vector_rx #(
    parameter int CLKS_PER_BIT = 108,
    parameter int N_NUMS       = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx,
    input  logic                     new_vector_incoming,
    output logic [N_NUMS-1:0][15:0]  rx_nums,
    output logic                     rx_available,
    output logic                     frame_error,
    output logic                     busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (N_NUMS > 1) ? $clog2(N_NUMS) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e                   state_q;
    logic                     rx_meta_q, rx_s_q, armed_q;
    logic [CW-1:0]            cnt_q;
    logic [2:0]               bit_q;
    logic [7:0]               shift_q;
    logic                     phase_q;
    logic [7:0]               hi_q;
    logic [IW-1:0]            idx_q;
    logic [N_NUMS-1:0][15:0]  shadow_q;
    logic [N_NUMS-1:0][15:0]  rx_nums_q;
    logic [N_NUMS-1:0][15:0]  vec_d;
    logic                     avail_q, ferr_q;
    logic                     cnt_done, byte_ok, byte_bad;

    assign cnt_done = (cnt_q == '0);
    assign byte_ok  = (state_q == STOP) && cnt_done &&  rx_s_q;
    assign byte_bad = (state_q == STOP) && cnt_done && !rx_s_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // armed_q keeps a held-low line (break) from being re-read as a new start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_s_q) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q <= START;
                        cnt_q   <= CW'(CLKS_PER_BIT / 2 - 1);
                    end
                end
                START: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (rx_s_q) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= DATA;
                        cnt_q   <= CW'(CLKS_PER_BIT - 1);
                        bit_q   <= '0;
                    end
                end
                DATA: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        shift_q[bit_q] <= rx_s_q;
                        cnt_q          <= CW'(CLKS_PER_BIT - 1);
                        if (bit_q == 3'd7) state_q <= STOP;
                        else               bit_q   <= bit_q + 3'd1;
                    end
                end
                STOP: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        state_q <= IDLE;
                        armed_q <= rx_s_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Completed vector: the shadow buffer with the word finishing right now merged in
    always_comb begin
        vec_d        = shadow_q;
        vec_d[idx_q] = {hi_q, shift_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q   <= 1'b0;
            hi_q      <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            rx_nums_q <= '0;
            avail_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            avail_q <= 1'b0;
            ferr_q  <= byte_bad;
            if (new_vector_incoming || byte_bad) begin
                idx_q   <= '0;
                phase_q <= 1'b0;
            end else if (byte_ok) begin
                if (!phase_q) begin
                    hi_q    <= shift_q;
                    phase_q <= 1'b1;
                end else begin
                    phase_q         <= 1'b0;
                    shadow_q[idx_q] <= {hi_q, shift_q};
                    if (idx_q == IW'(N_NUMS - 1)) begin
                        idx_q     <= '0;
                        rx_nums_q <= vec_d;
                        avail_q   <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
            end
        end
    end

    assign rx_nums      = rx_nums_q;
    assign rx_available = avail_q;
    assign frame_error  = ferr_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_uart_vector_rx.sv
// Scoreboard bench for uart_vector_rx: serial bytes are driven bit-accurately and
// each rx_available pulse pops the vector expected at that point.
module tb_uart_vector_rx;
    localparam int CPB = 27;
    localparam int N   = 5;

    typedef logic [N-1:0][15:0] vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx = 1'b1;
    logic nvi = 1'b0;
    vec_t rx_nums;
    logic rx_available, frame_error, busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   avail_cnt = 0;
    int   fe_cnt = 0;
    int   avail_cyc = 0;
    int   prev_avail_cyc = 0;
    vec_t last_nums;
    vec_t sb[$];

    uart_vector_rx #(.CLKS_PER_BIT(CPB), .N_NUMS(N)) dut (
        .clk(clk), .reset(reset), .rx(rx), .new_vector_incoming(nvi),
        .rx_nums(rx_nums), .rx_available(rx_available),
        .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on each strobe; otherwise rx_nums must hold
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                last_nums = '0;
                checks++;
                if (rx_nums !== '0) begin
                    errors++;
                    $display("FAIL reset_nums got=%h want=0", rx_nums);
                end
            end else if (rx_available) begin
                avail_cnt++;
                prev_avail_cyc = avail_cyc;
                avail_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_avail got=%h want=no pulse", rx_nums);
                end else begin
                    e = sb.pop_front();
                    if (rx_nums !== e) begin
                        errors++;
                        $display("FAIL vector got=%h want=%h", rx_nums, e);
                    end
                end
                last_nums = rx_nums;
            end else begin
                checks++;
                if (rx_nums !== last_nums) begin
                    errors++;
                    $display("FAIL nums_stable got=%h want=%h", rx_nums, last_nums);
                end
            end
            if (frame_error) fe_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [15:0] a, b, c, d, f);
        vec_t v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = f;
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
    endtask

    task automatic send_vec(input vec_t v);
        for (int i = 0; i < N; i++) begin
            send_byte(v[i][15:8]);
            send_byte(v[i][7:0]);
        end
    endtask

    task automatic push_send(input vec_t v);
        sb.push_back(v);
        send_vec(v);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic test_reset;
        idle(3);
        checks++;
        if (rx_nums !== '0) begin errors++; $display("FAIL rst_nums got=%h want=0", rx_nums); end
        checks++;
        if (rx_available !== 1'b0) begin errors++; $display("FAIL rst_avail got=%b want=0", rx_available); end
        checks++;
        if (frame_error !== 1'b0) begin errors++; $display("FAIL rst_ferr got=%b want=0", frame_error); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
        reset = 1'b1;
        idle(5);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_default;
        int a0, f0;
        a0 = avail_cnt; f0 = fe_cnt;
        push_send(mk(16'hF6A5, 16'hFEDA, 16'hFD3C, 16'h00C1, 16'hDABE));
        idle(10);
        chk("default_pulses", avail_cnt - a0, 1);
        chk("default_ferr", fe_cnt - f0, 0);
        chk("default_sb_empty", sb.size(), 0);
    endtask

    task automatic test_glitch;
        int a0;
        a0 = avail_cnt;
        rx = 1'b0;
        idle(CPB / 4);
        rx = 1'b1;
        idle(2 * CPB);
        chk("glitch_busy", int'(busy), 0);
        chk("glitch_no_pulse", avail_cnt - a0, 0);
        push_send(mk(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005));
        idle(10);
        chk("glitch_pulses", avail_cnt - a0, 1);
    endtask

    task automatic test_frame_error;
        int a0, f0;
        a0 = avail_cnt; f0 = fe_cnt;
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56, 1'b0);
        idle(CPB);
        chk("ferr_pulses", fe_cnt - f0, 1);
        push_send(mk(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555));
        idle(10);
        chk("ferr_vec_pulses", avail_cnt - a0, 1);
        chk("ferr_sb_empty", sb.size(), 0);
    endtask

    task automatic test_break;
        int a0, f0;
        a0 = avail_cnt; f0 = fe_cnt;
        rx = 1'b0;
        idle(20 * CPB);
        chk("break_ferr_once", fe_cnt - f0, 1);
        chk("break_busy", int'(busy), 0);
        rx = 1'b1;
        idle(2 * CPB);
        chk("break_ferr_after", fe_cnt - f0, 1);
        chk("break_no_pulse", avail_cnt - a0, 0);
    endtask

    task automatic test_resync;
        int a0;
        vec_t v;
        a0 = avail_cnt;
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'h99);
        v = mk(16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005);
        sb.push_back(v);
        fork
            send_vec(v);
            begin
                idle(3 * CPB);
                nvi = 1'b1;
                idle(1);
                nvi = 1'b0;
            end
        join
        idle(10);
        chk("resync_pulses", avail_cnt - a0, 1);
        chk("resync_sb_empty", sb.size(), 0);
    endtask

    task automatic test_reset_mid;
        int a0, f0;
        logic [7:0] b7;
        a0 = avail_cnt; f0 = fe_cnt;
        b7 = 8'hCC;
        for (int i = 0; i < 6; i++) send_byte(8'hB0 + 8'(i));
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b7[i];
            idle(CPB);
        end
        rx = b7[4];
        idle(CPB / 2);
        reset = 1'b0;
        idle(1);
        chk("midrst_busy", int'(busy), 0);
        rx = 1'b1;
        idle(3);
        reset = 1'b1;
        idle(2 * CPB);
        checks++;
        if (rx_nums !== '0) begin errors++; $display("FAIL midrst_nums got=%h want=0", rx_nums); end
        chk("midrst_no_pulse", avail_cnt - a0, 0);
        chk("midrst_no_ferr", fe_cnt - f0, 0);
        push_send(mk(16'h0BAD, 16'hCAFE, 16'h8000, 16'h7FFF, 16'hFFFF));
        idle(10);
        chk("midrst_pulses", avail_cnt - a0, 1);
    endtask

    task automatic test_back_to_back;
        int a0;
        a0 = avail_cnt;
        push_send(mk(16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0, 16'h0F0F));
        push_send(mk(16'hEC8A, 16'h6420, 16'h5555, 16'hAAAA, 16'h00FF));
        idle(10);
        chk("b2b_pulses", avail_cnt - a0, 2);
        chk("b2b_spacing", avail_cyc - prev_avail_cyc, 2 * N * 10 * CPB);
        chk("b2b_sb_empty", sb.size(), 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_default;
        test_glitch;
        test_frame_error;
        test_break;
        test_resync;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_vector_rx.md
Name: uart_vector_rx

Overview:
- Standalone serial receiver for the signed 16-bit number format (num); the receive-side counterpart of the vector transmitter in uart.
- Deserialises 8N1 UART bytes from a host or from a partner FPGA's tx line, assembles byte pairs into signed 16-bit words, and collects N_NUMS words into a vector.
- Presents the vector in parallel, held stable, with a one-cycle rx_available strobe.

Parameters:
- CLKS_PER_BIT, 108, clk cycles per serial bit (100 MHz / 921600 baud); must be >= 8.
- N_NUMS, 5, words per vector.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- new_vector_incoming  input  1  synchronous one-cycle strobe; restarts vector assembly at word 0, high byte.
- rx_nums  output  N_NUMS x 16 signed  last complete vector; rx_nums[0] is the first word received.
- rx_available  output  1  one-cycle pulse when rx_nums has been updated.
- frame_error  output  1  one-cycle pulse when a stop bit is sampled low.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (reset low, async):
  - rx_nums all 0; rx_available, frame_error and busy 0.
  - FSM to IDLE; word index and byte phase 0.
  - Synchroniser flops set to 1.
- Input sync: rx passes through a 2-FF synchroniser before use (rx_s). All timing below is relative to rx_s.
- FSM states:
  - IDLE: on rx_s == 0, go to START and load the bit counter with CLKS_PER_BIT/2 - 1.
  - START: at counter expiry, resample rx_s.
    - If 1: false start; return to IDLE with no outputs.
    - If 0: go to DATA, load the counter with CLKS_PER_BIT - 1, bit index 0.
  - DATA: at each counter expiry, sample rx_s into shift-register bit [bit index] (LSB first). After bit 7, go to STOP.
  - STOP: at counter expiry (mid stop bit), sample rx_s.
    - If 1: byte valid; hand it to the assembler.
    - If 0: frame_error pulses next cycle, the byte is discarded, and word index and byte phase clear to 0.
    - Either way return to IDLE. The next start bit may be detected from the cycle after.
- Byte assembly:
  - Within a word, the high byte is received first, then the low byte.
  - When the low byte completes, the word is written to shadow buffer[word index] and word index increments.
  - When word index reaches N_NUMS - 1 and its low byte completes:
    - the whole shadow buffer (including this word) copies to rx_nums;
    - rx_available pulses on the next cycle (2 clks after the stop-bit mid-sample, counting the synchroniser);
    - word index wraps to 0.
- rx_nums changes only on that copy. It is stable between rx_available pulses, including during partial vectors and errors.
- new_vector_incoming: clears word index and byte phase immediately. An in-flight serial byte is not aborted; it becomes the high byte of word 0.
  - If it coincides with a valid byte completing, the clear wins and that byte is discarded.
  - Partially filled shadow words are not cleared; they are simply overwritten.
- Simultaneous frame_error and new_vector_incoming: both clear; frame_error still pulses.
- Reset asserted mid-byte: everything returns to reset values; no pulse is emitted.
- Line held low (break): one frame_error, then the FSM stays in IDLE until rx_s returns high and falls again. IDLE re-arms only after rx_s has been seen high for at least one cycle.

Test Plan:
1. Defaults (CLKS_PER_BIT=108, N_NUMS=5). Send bytes F6 A5 FE DA FD 3C 00 C1 DA BE at 921600 baud -> exactly one rx_available pulse after the last stop bit. rx_nums = {[0]=16'hF6A5, [1]=16'hFEDA, [2]=16'hFD3C, [3]=16'h00C1, [4]=16'hDABE}. frame_error never asserted.
2. Glitch: rx low for 30 clks, then high -> FSM returns to IDLE from START; no byte assembled; a following full vector of 0x0001..0x0005 is received correctly.
3. Frame error: send 12 34, then byte 56 with a low stop bit -> frame_error pulses once. Then send 10 complete bytes 11 11 22 22 33 33 44 44 55 55 -> rx_nums = 1111, 2222, 3333, 4444, 5555. The earlier 1234 must not appear.
4. Resync: send 3 bytes, pulse new_vector_incoming, then send a full 10-byte vector A0 01 .. A0 05 -> single rx_available; rx_nums = A001..A005.
5. Reset mid-operation: assert reset low during bit 4 of byte 7 -> rx_nums stays 0 and no rx_available pulse. A full vector sent after release is captured intact.
6. Back-to-back: two vectors sent with no idle gap -> two rx_available pulses exactly 100 bit-times apart. The second vector replaces the first atomically; rx_nums never shows a mix of old and new words.
